// File: rtl/gpio_pattern_seq.sv
// gpio_pattern_seq: RAM-backed pattern player for the GPIO header.
// Patterns are written into a small inferred RAM and replayed onto gpio_out,
// one entry every P = max(step_div, 2) cycles, either once or looped.
module gpio_pattern_seq #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   len,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              loop_en,
  output logic [DATA_W-1:0] gpio_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_HOLD,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  cur_idx_q, cur_idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   per_q, per_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic               loop_q, loop_d;
  logic [DATA_W-1:0]  gpio_q, gpio_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rdata_q;

  logic [ADDR_W:0]    len_m1;
  logic [ADDR_W-1:0]  nxt_rd;
  logic               is_last;
  logic               len_ok;
  logic [DIV_W-1:0]   step_eff;
  logic               rd_en;

  // Read is only strobed right after rd_addr moves, so a later write to an
  // already-prefetched entry cannot disturb the copy used this pass.
  always_comb begin
    len_m1   = len_q - (ADDR_W+1)'(1);
    nxt_rd   = ({1'b0, rd_addr_q} == len_m1) ? '0 : rd_addr_q + ADDR_W'(1);
    is_last  = ({1'b0, cur_idx_q} == len_m1);
    len_ok   = (len != '0) && (len <= (ADDR_W+1)'(DEPTH));
    step_eff = (step_div < DIV_W'(2)) ? DIV_W'(2) : step_div;
    rd_en    = (state_q == S_FETCH) || ((state_q == S_HOLD) && (cnt_q == '0));
  end

  // RAM: synchronous write, registered read; same-address collision yields old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rdata_q <= mem[rd_addr_q];
  end

  // Next-state and output computation for the playback FSM.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    cur_idx_d = cur_idx_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    len_d     = len_q;
    loop_d    = loop_q;
    gpio_d    = gpio_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop && len_ok) begin
          len_d     = len;
          per_d     = step_eff;
          loop_d    = loop_en;
          rd_addr_d = '0;
          cnt_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = stop ? S_IDLE : S_LOAD;
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          gpio_d    = rdata_q;
          cur_idx_d = rd_addr_q;
          cnt_d     = '0;
          rd_addr_d = nxt_rd;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (stop) begin
          state_d = S_IDLE;
        end else if (is_last && !loop_q && (cnt_q == per_q - DIV_W'(2))) begin
          // Last entry of a one-shot run: the DONE cycle is its final cycle.
          state_d = S_DONE;
        end else if (cnt_q == per_q - DIV_W'(1)) begin
          gpio_d    = rdata_q;
          cur_idx_d = rd_addr_q;
          cnt_d     = '0;
          rd_addr_d = nxt_rd;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      gpio_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      cur_idx_q <= cur_idx_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      gpio_q    <= gpio_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gpio_out = gpio_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cur_idx  = cur_idx_q;

endmodule
